// File: rtl/mul_arbiter.sv
// mul_arbiter: two-requester round-robin front end for a shared
// floating-point multiplier.
//
// The arbiter picks one requester, captures that requester's operands and
// hands them to the multiplier. It then waits up to TIMEOUT cycles for
// mul_done and returns either the product or a zero error response. The
// 32-bit operands and the product pass through unmodified.
//
// Parameters
//   TIMEOUT    maximum WAIT cycles allowed for mul_done before the
//              transaction is aborted with resp_err=1.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[1:0]   per-requester request, held until the matching ack
//   req_op1_0, req_op2_0   requester 0 operands
//   req_op1_1, req_op2_1   requester 1 operands
//   ack[1:0]   one-hot, one-cycle grant pulse (ISSUE cycle)
//   resp_valid one-cycle result strobe (RESP cycle)
//   resp_id    owner of the current/last result
//   resp_data  product, or zero after a timeout
//   resp_err   set when the last transaction timed out
//   mul_start  one-cycle multiplier start pulse (ISSUE cycle)
//   mul_op1, mul_op2       operands held for the multiplier
//   mul_done   multiplier completion, only honoured in WAIT
//   mul_result multiplier product, valid with mul_done
//   busy       high whenever the arbiter is not IDLE
module mul_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] req_op1_0,
  input  logic [31:0] req_op2_0,
  input  logic [31:0] req_op1_1,
  input  logic [31:0] req_op2_1,
  output logic [1:0]  ack,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mul_start,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic        mul_done,
  input  logic [31:0] mul_result,
  output logic        busy
);

  localparam int DATA_W = 32;

  // Timer only has to reach TIMEOUT-1; it is compared before incrementing,
  // so it never wraps.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              id;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic              win_id;

  // On a tie the requester that was not served last wins; a sole requester
  // always wins.
  always_comb begin
    win_id = 1'b0;
    if (req == 2'b11) begin
      win_id = ~last_grant;
    end else begin
      win_id = req[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      timer      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      ack        <= 2'b00;
      mul_start  <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised only on the transition
      // into the state that owns it.
      ack        <= 2'b00;
      mul_start  <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            id        <= win_id;
            op1_q     <= win_id ? req_op1_1 : req_op1_0;
            op2_q     <= win_id ? req_op2_1 : req_op2_0;
            ack       <= win_id ? 2'b10 : 2'b01;
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // mul_done takes priority over a timeout in the same cycle.
          if (mul_done) begin
            resp_data  <= mul_result;
            resp_err   <= 1'b0;
            resp_id    <= id;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (timer == TMR_LAST) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_id    <= id;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RESP: begin
          last_grant <= id;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mul_op1 = op1_q;
  assign mul_op2 = op2_q;
  assign busy    = (state != IDLE);

endmodule
